// File: rtl/cardinal_pkg.sv
// Shared definitions for the cardinal ring router: flit geometry, flit type
// and virtual-channel encoding.
package cardinal_pkg;

  localparam int FLIT_WIDTH    = 64;
  localparam int VC_IDX        = 0;
  localparam int HOP_FIELD_MSB = 16;
  localparam int HOP_FIELD_LSB = 23;
  localparam int HOP_WIDTH     = HOP_FIELD_LSB - HOP_FIELD_MSB + 1;

  // Big-endian bit numbering: bit 0 is the leftmost (VC) bit.
  typedef logic [0:FLIT_WIDTH-1] flit_t;

  typedef enum logic {
    EVEN = 1'b0,
    ODD  = 1'b1
  } vc_e;

endpackage

// File: rtl/cardinal_vc_slot.sv
// Two-VC single-entry flit buffer: one write port and one clear port, each
// addressed by VC, with per-VC full flags and read data.
module cardinal_vc_slot
  import cardinal_pkg::*;
#(
  parameter int W = FLIT_WIDTH
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               wr_en,
  input  logic               wr_vc,
  input  logic [0:W-1]       wr_data,
  input  logic               clr_en,
  input  logic               clr_vc,
  output logic [1:0]         full,
  output logic [1:0][0:W-1]  data
);

  always_ff @(posedge clk) begin
    if (!reset) begin
      full <= '0;
    end else begin
      for (int v = 0; v < 2; v++) begin
        if (wr_en && (wr_vc == 1'(v))) begin
          full[v] <= 1'b1;
        end else if (clr_en && (clr_vc == 1'(v))) begin
          full[v] <= 1'b0;
        end
      end
    end
  end

  // Payload needs no reset; it is only observed while the full flag is set.
  always_ff @(posedge clk) begin
    for (int v = 0; v < 2; v++) begin
      if (wr_en && (wr_vc == 1'(v))) begin
        data[v] <= wr_data;
      end
    end
  end

endmodule

// File: rtl/cardinal_ring_router.sv
// One clockwise ring node with local PE port, even/odd VC buffering and
// polarity-phased link/switch use. Optional counters: FLIT_COUNTERS_EN.
module cardinal_ring_router
  import cardinal_pkg::*;
#(
  parameter int DATA_WIDTH = FLIT_WIDTH,
  parameter int HOP_MSB    = HOP_FIELD_MSB,
  parameter int HOP_LSB    = HOP_FIELD_LSB
) (
  input  logic                  clk,
  input  logic                  reset,
  output logic                  polarity,
  input  logic                  cwsi,
  output logic                  cwri,
  input  logic [0:DATA_WIDTH-1] cwdi,
  output logic                  cwso,
  input  logic                  cwro,
  output logic [0:DATA_WIDTH-1] cwdo,
  input  logic                  pesi,
  output logic                  peri,
  input  logic [0:DATA_WIDTH-1] pedi,
  output logic                  peso,
  input  logic                  pero,
  output logic [0:DATA_WIDTH-1] pedo
`ifdef FLIT_COUNTERS_EN
  ,
  output logic [31:0]           eject_count,
  output logic [31:0]           fwd_count
`endif
);

  localparam int HW = HOP_LSB - HOP_MSB + 1;

  function automatic logic [0:DATA_WIDTH-1] dec_hop(input logic [0:DATA_WIDTH-1] f);
    logic [0:DATA_WIDTH-1] r;
    r = f;
    r[HOP_MSB:HOP_LSB] = f[HOP_MSB:HOP_LSB] - HW'(1);
    return r;
  endfunction

  logic p;
  vc_e  ext_vc;
  vc_e  int_vc;

  logic [1:0]                  icw_full, ipe_full, ocw_full, ope_full;
  logic [1:0][0:DATA_WIDTH-1]  icw_data, ipe_data, ocw_data, ope_data;

  logic icw_wr, ipe_wr, ocw_wr, ope_wr;
  logic icw_clr, ipe_clr, ocw_clr, ope_clr;
  logic [0:DATA_WIDTH-1] ocw_wdata, ope_wdata;

  logic [0:DATA_WIDTH-1] cw_flit, pe_flit;
  logic cw_hop0, pe_hop0;
  logic req_cw_ocw, req_cw_ope, req_pe_ocw, req_pe_ope;
  logic g_cw_ocw, g_pe_ocw, g_cw_ope, g_pe_ope;
  logic ptr_cw, ptr_pe, ptr_cw_nxt, ptr_pe_nxt;

  assign ext_vc = vc_e'(p);
  assign int_vc = vc_e'(~p);

  assign polarity = p;
  assign cwri     = ~icw_full[ext_vc];
  assign peri     = ~ipe_full[ext_vc];
  assign cwso     = ocw_full[ext_vc];
  assign peso     = ope_full[ext_vc];
  assign cwdo     = ocw_data[ext_vc];
  assign pedo     = ope_data[ext_vc];

  // External phase: link handshakes on VC p.
  assign icw_wr  = cwsi & cwri;
  assign ipe_wr  = pesi & peri;
  assign ocw_clr = cwso & cwro;
  assign ope_clr = peso & pero;

  // Internal phase: route the ~p input slots by remaining hop count.
  assign cw_flit    = icw_data[int_vc];
  assign pe_flit    = ipe_data[int_vc];
  assign cw_hop0    = (cw_flit[HOP_MSB:HOP_LSB] == '0);
  assign pe_hop0    = (pe_flit[HOP_MSB:HOP_LSB] == '0);
  assign req_cw_ocw = icw_full[int_vc] & ~cw_hop0;
  assign req_cw_ope = icw_full[int_vc] &  cw_hop0;
  assign req_pe_ocw = ipe_full[int_vc] & ~pe_hop0;
  assign req_pe_ope = ipe_full[int_vc] &  pe_hop0;

  // Pointer 0 favours the ring input, 1 favours the PE input.
  always_comb begin
    g_cw_ocw   = 1'b0;
    g_pe_ocw   = 1'b0;
    g_cw_ope   = 1'b0;
    g_pe_ope   = 1'b0;
    ptr_cw_nxt = ptr_cw;
    ptr_pe_nxt = ptr_pe;
    if (!ocw_full[int_vc]) begin
      if (req_cw_ocw && req_pe_ocw) begin
        g_cw_ocw   = ~ptr_cw;
        g_pe_ocw   =  ptr_cw;
        ptr_cw_nxt = ~ptr_cw;
      end else begin
        g_cw_ocw = req_cw_ocw;
        g_pe_ocw = req_pe_ocw;
      end
    end
    if (!ope_full[int_vc]) begin
      if (req_cw_ope && req_pe_ope) begin
        g_cw_ope   = ~ptr_pe;
        g_pe_ope   =  ptr_pe;
        ptr_pe_nxt = ~ptr_pe;
      end else begin
        g_cw_ope = req_cw_ope;
        g_pe_ope = req_pe_ope;
      end
    end
  end

  assign ocw_wr    = g_cw_ocw | g_pe_ocw;
  assign ope_wr    = g_cw_ope | g_pe_ope;
  assign ocw_wdata = dec_hop(g_pe_ocw ? pe_flit : cw_flit);
  assign ope_wdata = g_pe_ope ? pe_flit : cw_flit;
  assign icw_clr   = g_cw_ocw | g_cw_ope;
  assign ipe_clr   = g_pe_ocw | g_pe_ope;

  always_ff @(posedge clk) begin
    if (!reset) begin
      p      <= 1'b0;
      ptr_cw <= 1'b0;
      ptr_pe <= 1'b0;
    end else begin
      p      <= ~p;
      ptr_cw <= ptr_cw_nxt;
      ptr_pe <= ptr_pe_nxt;
    end
  end

  cardinal_vc_slot #(.W(DATA_WIDTH)) u_in_cw (
    .clk(clk), .reset(reset),
    .wr_en(icw_wr), .wr_vc(ext_vc), .wr_data(cwdi),
    .clr_en(icw_clr), .clr_vc(int_vc),
    .full(icw_full), .data(icw_data)
  );

  cardinal_vc_slot #(.W(DATA_WIDTH)) u_in_pe (
    .clk(clk), .reset(reset),
    .wr_en(ipe_wr), .wr_vc(ext_vc), .wr_data(pedi),
    .clr_en(ipe_clr), .clr_vc(int_vc),
    .full(ipe_full), .data(ipe_data)
  );

  cardinal_vc_slot #(.W(DATA_WIDTH)) u_out_cw (
    .clk(clk), .reset(reset),
    .wr_en(ocw_wr), .wr_vc(int_vc), .wr_data(ocw_wdata),
    .clr_en(ocw_clr), .clr_vc(ext_vc),
    .full(ocw_full), .data(ocw_data)
  );

  cardinal_vc_slot #(.W(DATA_WIDTH)) u_out_pe (
    .clk(clk), .reset(reset),
    .wr_en(ope_wr), .wr_vc(int_vc), .wr_data(ope_wdata),
    .clr_en(ope_clr), .clr_vc(ext_vc),
    .full(ope_full), .data(ope_data)
  );

`ifdef FLIT_COUNTERS_EN
  always_ff @(posedge clk) begin
    if (!reset) begin
      eject_count <= '0;
      fwd_count   <= '0;
    end else begin
      if (ope_clr) eject_count <= eject_count + 32'd1;
      if (ocw_clr) fwd_count   <= fwd_count + 32'd1;
    end
  end
`endif

endmodule

// File: tb/tb_cardinal_ring_router.sv
// Self-checking bench for cardinal_ring_router: directed vector table, corner
// sequences, and randomized traffic against a slot-array reference model.
module tb_cardinal_ring_router;
  import cardinal_pkg::*;

  logic  clk = 1'b0;
  always #5 clk = ~clk;

  logic  reset;
  logic  polarity;
  logic  cwsi, cwri, cwso, cwro;
  logic  pesi, peri, peso, pero;
  flit_t cwdi, cwdo, pedi, pedo;
`ifdef FLIT_COUNTERS_EN
  logic [31:0] eject_count, fwd_count;
`endif

  cardinal_ring_router dut (
    .clk(clk), .reset(reset), .polarity(polarity),
    .cwsi(cwsi), .cwri(cwri), .cwdi(cwdi),
    .cwso(cwso), .cwro(cwro), .cwdo(cwdo),
    .pesi(pesi), .peri(peri), .pedi(pedi),
    .peso(peso), .pero(pero), .pedo(pedo)
`ifdef FLIT_COUNTERS_EN
    , .eject_count(eject_count), .fwd_count(fwd_count)
`endif
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic chk_ctl(input string tag, input logic e_pol, input logic e_cwri,
                         input logic e_peri, input logic e_cwso, input logic e_peso);
    chk({tag, ".pol"},  64'(polarity), 64'(e_pol));
    chk({tag, ".cwri"}, 64'(cwri),     64'(e_cwri));
    chk({tag, ".peri"}, 64'(peri),     64'(e_peri));
    chk({tag, ".cwso"}, 64'(cwso),     64'(e_cwso));
    chk({tag, ".peso"}, 64'(peso),     64'(e_peso));
  endtask

  function automatic flit_t mk(input logic vc, input logic [7:0] hop, input logic [31:0] pay);
    flit_t f;
    f = '0;
    f[0] = vc;
    f[16:23] = hop;
    f[32:63] = pay;
    return f;
  endfunction

  function automatic flit_t dec(input flit_t f);
    flit_t r;
    r = f;
    r[16:23] = f[16:23] - 8'd1;
    return r;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    cwsi = 0; pesi = 0; cwdi = '0; pedi = '0; cwro = 1; pero = 1;
  endtask

  task automatic do_reset();
    idle();
    reset = 0;
    step(); step();
    reset = 1;
  endtask

  // ---------------- reference model ----------------
  localparam int ICW = 0, IPE = 1, OCW = 2, OPE = 3;
  bit          mf [4][2];
  flit_t       md [4][2];
  bit          mp;
  bit          mptr [2];
  int unsigned m_ej, m_fw;

  task automatic model_reset();
    for (int s = 0; s < 4; s++) for (int v = 0; v < 2; v++) begin
      mf[s][v] = 0; md[s][v] = '0;
    end
    mp = 0; mptr[0] = 0; mptr[1] = 0; m_ej = 0; m_fw = 0;
  endtask

  task automatic model_step(input logic csi, input flit_t cdi, input logic psi,
                            input flit_t pdi, input logic cro, input logic pro);
    bit    nf [4][2];
    flit_t nd [4][2];
    int    cand[$];
    int    e, iv, w;
    nf = mf; nd = md;
    e = int'(mp); iv = int'(!mp);
    if (cro && mf[OCW][e]) begin nf[OCW][e] = 0; m_fw++; end
    if (pro && mf[OPE][e]) begin nf[OPE][e] = 0; m_ej++; end
    if (csi && !mf[ICW][e]) begin nf[ICW][e] = 1; nd[ICW][e] = cdi; end
    if (psi && !mf[IPE][e]) begin nf[IPE][e] = 1; nd[IPE][e] = pdi; end
    for (int t = OCW; t <= OPE; t++) begin
      cand.delete();
      for (int s = ICW; s <= IPE; s++)
        if (mf[s][iv] && ((md[s][iv][16:23] != 8'd0) == (t == OCW))) cand.push_back(s);
      if (!mf[t][iv] && cand.size() > 0) begin
        w = cand[0];
        if (cand.size() == 2) begin
          w = mptr[t-OCW] ? IPE : ICW;
          mptr[t-OCW] = !mptr[t-OCW];
        end
        nf[w][iv] = 0;
        nf[t][iv] = 1;
        nd[t][iv] = (t == OCW) ? dec(md[w][iv]) : md[w][iv];
      end
    end
    mf = nf; md = nd; mp = !mp;
  endtask

  // ---------------- directed vector table ----------------
  typedef struct {
    logic  cwsi; flit_t cwdi; logic pesi; flit_t pedi; logic cwro; logic pero;
    logic  e_pol, e_cwri, e_peri, e_cwso, e_peso;
    flit_t e_cwdo, e_pedo;
  } vec_t;

  vec_t  vt [10];
  flit_t fa, ff, fz, c1, p1, fb;

  initial begin
    reset = 0;
    idle();
    fz = '0;
    fa = mk(0, 8'd0, 32'h0000_00A5);
    ff = mk(1, 8'd3, 32'h1234_5678);
    //          cwsi cwdi pesi pedi cwro pero pol cwri peri cwso peso cwdo      pedo
    vt[0] = '{0, fz, 1, fa, 1, 1, 0, 1, 1, 0, 0, fz,       fz};
    vt[1] = '{0, fz, 0, fz, 1, 1, 1, 1, 1, 0, 0, fz,       fz};
    vt[2] = '{0, fz, 0, fz, 1, 1, 0, 1, 1, 0, 1, fz,       fa};
    vt[3] = '{0, fz, 0, fz, 1, 1, 1, 1, 1, 0, 0, fz,       fz};
    vt[4] = '{0, fz, 0, fz, 1, 1, 0, 1, 1, 0, 0, fz,       fz};
    vt[5] = '{1, ff, 0, fz, 1, 1, 1, 1, 1, 0, 0, fz,       fz};
    vt[6] = '{0, fz, 0, fz, 1, 1, 0, 1, 1, 0, 0, fz,       fz};
    vt[7] = '{0, fz, 0, fz, 1, 1, 1, 1, 1, 1, 0, dec(ff),  fz};
    vt[8] = '{0, fz, 0, fz, 1, 1, 0, 1, 1, 0, 0, fz,       fz};
    vt[9] = '{0, fz, 0, fz, 1, 1, 1, 1, 1, 0, 0, fz,       fz};

    do_reset();
    chk_ctl("reset", 0, 1, 1, 0, 0);

    for (int i = 0; i < 10; i++) begin
      cwsi = vt[i].cwsi; cwdi = vt[i].cwdi; pesi = vt[i].pesi; pedi = vt[i].pedi;
      cwro = vt[i].cwro; pero = vt[i].pero;
      chk_ctl($sformatf("vec%0d", i), vt[i].e_pol, vt[i].e_cwri, vt[i].e_peri,
              vt[i].e_cwso, vt[i].e_peso);
      if (vt[i].e_cwso) chk($sformatf("vec%0d.cwdo", i), cwdo, vt[i].e_cwdo);
      if (vt[i].e_peso) chk($sformatf("vec%0d.pedo", i), pedo, vt[i].e_pedo);
      step();
    end
    idle();

    // Backpressure: second flit waits in in_cw[0]; an offer while cwri=0 is ignored.
    do_reset();
    fa = mk(0, 8'd2, 32'h1); fb = mk(0, 8'd2, 32'h2);
    cwro = 0; cwsi = 1; cwdi = fa; step();
    cwsi = 0; step();
    chk_ctl("bp.c2", 0, 1, 1, 1, 0);
    chk("bp.c2.cwdo", cwdo, dec(fa));
    cwsi = 1; cwdi = fb; step();
    cwsi = 0; step();
    chk_ctl("bp.c4", 0, 0, 1, 1, 0);
    chk("bp.c4.cwdo", cwdo, dec(fa));
    cwsi = 1; cwdi = mk(0, 8'd2, 32'hBAD); cwro = 1; step();
    cwsi = 0;
    chk_ctl("bp.c5", 1, 1, 1, 0, 0);
    step();
    chk_ctl("bp.c6", 0, 1, 1, 1, 0);
    chk("bp.c6.cwdo", cwdo, dec(fb));
    step(); step();
    chk_ctl("bp.c8", 0, 1, 1, 0, 0);
    step(); step();
    chk_ctl("bp.c10", 0, 1, 1, 0, 0);

    // Conflict: both inputs target out_cw[0]; pointer alternates the winner.
    do_reset();
    for (int r = 0; r < 2; r++) begin
      c1 = mk(0, 8'd1, 32'hC000 + r);
      p1 = mk(0, 8'd1, 32'hE000 + r);
      cwsi = 1; cwdi = c1; pesi = 1; pedi = p1; step();
      idle(); step();
      chk($sformatf("cf%0d.first.cwso", r), 64'(cwso), 64'd1);
      chk($sformatf("cf%0d.first.cwdo", r), cwdo, (r == 0) ? dec(c1) : dec(p1));
      step(); step();
      chk($sformatf("cf%0d.second.cwso", r), 64'(cwso), 64'd1);
      chk($sformatf("cf%0d.second.cwdo", r), cwdo, (r == 0) ? dec(p1) : dec(c1));
      step(); step();
      chk($sformatf("cf%0d.empty.cwso", r), 64'(cwso), 64'd0);
    end

    // Reset mid-operation with every slot loaded.
    do_reset();
    cwro = 0; pero = 0;
    for (int k = 0; k < 4; k++) begin
      cwsi = 1; pesi = 1;
      cwdi = mk(1'(k), 8'd1, 32'(k));
      pedi = mk(1'(k), 8'd0, 32'(k));
      step();
    end
    cwsi = 0; pesi = 0;
    chk_ctl("rm.full", 0, 0, 0, 1, 1);
    reset = 0; step(); reset = 1;
    chk_ctl("rm.after", 0, 1, 1, 0, 0);
    cwro = 1; pero = 1;
    for (int k = 0; k < 8; k++) begin
      step();
      chk($sformatf("rm.stale%0d", k), {62'd0, cwso, peso}, 64'd0);
    end

    // Randomized traffic against the reference model.
    do_reset();
    model_reset();
    for (int n = 0; n < 3000; n++) begin
      cwsi = 1'($urandom_range(0, 1));
      pesi = 1'($urandom_range(0, 1));
      cwdi = mk(mp, 8'($urandom_range(0, 3)), $urandom);
      pedi = mk(mp, 8'($urandom_range(0, 3)), $urandom);
      cwro = ($urandom_range(0, 3) != 0);
      pero = ($urandom_range(0, 3) != 0);
      chk_ctl("rnd", mp, !mf[ICW][mp], !mf[IPE][mp], mf[OCW][mp], mf[OPE][mp]);
      if (mf[OCW][mp]) chk("rnd.cwdo", cwdo, md[OCW][mp]);
      if (mf[OPE][mp]) chk("rnd.pedo", pedo, md[OPE][mp]);
      model_step(cwsi, cwdi, pesi, pedi, cwro, pero);
      step();
    end
    idle();

`ifdef FLIT_COUNTERS_EN
    chk("rnd.eject_count", 64'(eject_count), 64'(m_ej));
    chk("rnd.fwd_count",   64'(fwd_count),   64'(m_fw));
    do_reset();
    chk("cnt.reset.eject", 64'(eject_count), 64'd0);
    chk("cnt.reset.fwd",   64'(fwd_count),   64'd0);
    for (int k = 0; k < 5; k++) begin
      pesi = 1; pedi = mk(0, 8'd0, 32'(k));
      cwsi = (k < 3); cwdi = mk(0, 8'd1, 32'(k));
      step();
      cwsi = 0; pesi = 0;
      step();
    end
    step(); step(); step(); step();
    chk("cnt.eject", 64'(eject_count), 64'd5);
    chk("cnt.fwd",   64'(fwd_count),   64'd3);
    do_reset();
    chk("cnt.reset2.eject", 64'(eject_count), 64'd0);
    chk("cnt.reset2.fwd",   64'(fwd_count),   64'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
